// File: rtl/line_codec_pkg.sv
// Shared definitions for the line encoder: default geometry, output state
// encoding and the line-index to code mapping used by the 3-to-8 decoder.
package line_codec_pkg;

    localparam int LINES  = 8;
    localparam int CODE_W = 3;

    // The output state is exactly the Valid register: EMPTY=0, HOLD=1.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Decoder-compatible code: the highest line maps to code 0, line 0 to the
    // largest code. Callers truncate the result to their code width.
    function automatic int unsigned line_to_code(input int unsigned i,
                                                 input int unsigned lines = LINES);
        return lines - 1 - i;
    endfunction

endpackage

// File: rtl/line_priority_pick.sv
// Combinational priority selector: finds the highest set bit of a bitmap
// and reports its decoder-compatible code and one-hot mask.
module line_priority_pick
    import line_codec_pkg::*;
#(
    parameter int LINES  = line_codec_pkg::LINES,
    parameter int CODE_W = line_codec_pkg::CODE_W
) (
    input  logic [LINES-1:0]  bitmap,
    output logic              any,
    output logic [CODE_W-1:0] code,
    output logic [LINES-1:0]  mask
);

    // Scan upward so the last (highest) set bit overrides lower ones.
    always_comb begin
        any  = |bitmap;
        code = '0;
        mask = '0;
        for (int i = 0; i < LINES; i++) begin
            if (bitmap[i]) begin
                code    = CODE_W'(line_to_code(i, LINES));
                mask    = '0;
                mask[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_encoder_sequencer.sv
// Registered priority encoder: captures request pulses into a pending
// bitmap and issues one code per pending line over a Valid/Ready handshake,
// highest line first, back-to-back when the consumer keeps Ready high.
module line_encoder_sequencer
    import line_codec_pkg::*;
#(
    parameter int LINES  = line_codec_pkg::LINES,
    parameter int CODE_W = line_codec_pkg::CODE_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [LINES-1:0]  d,
    input  logic              ready,
    output logic              valid,
    output logic [CODE_W-1:0] code,
    output logic [LINES-1:0]  pending,
    output logic              merge
);

    state_t             state_reg, state_next;
    logic [CODE_W-1:0]  code_reg, code_next;
    logic [LINES-1:0]   pending_reg, pending_next;
    logic               merge_reg, merge_next;

    logic               pick_any;
    logic [CODE_W-1:0]  pick_code;
    logic [LINES-1:0]   pick_mask;

    logic               load;
    logic [LINES-1:0]   load_mask;
    logic [LINES-1:0]   held_mask;
    logic [LINES-1:0]   capture;
    logic [LINES-1:0]   remain;

    line_priority_pick #(
        .LINES  (LINES),
        .CODE_W (CODE_W)
    ) u_pick (
        .bitmap (pending_reg),
        .any    (pick_any),
        .code   (pick_code),
        .mask   (pick_mask)
    );

    // One-hot of the line currently held in Code that is not being accepted;
    // a new request for it is a duplicate rather than a fresh episode.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_held
            assign held_mask[gi] = (state_reg == ST_HOLD) && !ready &&
                                   (code_reg == CODE_W'(line_to_code(gi, LINES)));
        end
    endgenerate

    // Next-state logic: decide whether a new code is loaded this cycle.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (pick_any) begin
                    state_next = ST_HOLD;
                    load       = 1'b1;
                end
            end
            ST_HOLD: begin
                if (ready) begin
                    if (pick_any) begin
                        load = 1'b1;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Datapath: clear the loaded line, then OR in captures (set wins).
    always_comb begin
        load_mask    = load ? pick_mask : '0;
        capture      = enable ? d : '0;
        remain       = pending_reg & ~load_mask;
        pending_next = remain | (capture & ~held_mask);
        code_next    = load ? pick_code : code_reg;
        merge_next   = |(capture & (remain | held_mask));
    end

    // State register; reset discards held and pending requests.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_EMPTY;
            code_reg    <= '0;
            pending_reg <= '0;
            merge_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            code_reg    <= code_next;
            pending_reg <= pending_next;
            merge_reg   <= merge_next;
        end
    end

    assign valid   = (state_reg == ST_HOLD);
    assign code    = code_reg;
    assign pending = pending_reg;
    assign merge   = merge_reg;

endmodule

// File: tb/tb_line_encoder_sequencer.sv
// Directed bench for line_encoder_sequencer with a code scoreboard: the
// expected issue order is queued as requests are driven and checked on
// every handshake.
module tb_line_encoder_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] d;
    logic       ready;
    logic       valid;
    logic [2:0] code;
    logic [7:0] pending;
    logic       merge;

    int         vectors    = 0;
    int         miscompares = 0;
    logic [2:0] exp_q[$];

    line_encoder_sequencer dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .d       (d),
        .ready   (ready),
        .valid   (valid),
        .code    (code),
        .pending (pending),
        .merge   (merge)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] c,
                             input logic [7:0] p, input logic m);
        check({tag, " valid"},   {7'b0, valid}, {7'b0, v});
        check({tag, " code"},    {5'b0, code},  {5'b0, c});
        check({tag, " pending"}, pending,       p);
        check({tag, " merge"},   {7'b0, merge}, {7'b0, m});
    endtask

    // Scoreboard: a handshake that completes on the next rising edge is seen
    // here half a cycle early, while inputs and outputs are stable.
    always @(negedge clock) begin
        if (!reset && valid && ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $error("FAIL issue: observed code %0d expected no issue", code);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                $display("issue code %0d (expected %0d)", code, e);
                assert (code === e) else begin
                    miscompares++;
                    $error("FAIL issue: observed code %0d expected %0d", code, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b1; d = 8'hFF; ready = 1'b0;

        // Reset dominates capture
        step(); check_out("reset1", 1'b0, 3'd0, 8'h00, 1'b0);
        step(); check_out("reset2", 1'b0, 3'd0, 8'h00, 1'b0);
        reset = 1'b0; d = 8'h00;
        step(); check_out("idle1", 1'b0, 3'd0, 8'h00, 1'b0);
        step(); check_out("idle2", 1'b0, 3'd0, 8'h00, 1'b0);

        // Single request on line 2
        ready = 1'b1; d = 8'h04; exp_q.push_back(3'b101);
        step(); check_out("single_cap", 1'b0, 3'd0, 8'h04, 1'b0);
        d = 8'h00;
        step(); check_out("single_issue", 1'b1, 3'b101, 8'h00, 1'b0);
        step(); check_out("single_done", 1'b0, 3'b101, 8'h00, 1'b0);

        // Multi-request with backpressure
        ready = 1'b0; d = 8'h91;
        exp_q.push_back(3'b000); exp_q.push_back(3'b011); exp_q.push_back(3'b111);
        step(); check_out("multi_cap", 1'b0, 3'b101, 8'h91, 1'b0);
        d = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step(); check_out("multi_hold", 1'b1, 3'b000, 8'h11, 1'b0);
        end
        ready = 1'b1;
        step(); check_out("multi_b2b1", 1'b1, 3'b011, 8'h01, 1'b0);
        step(); check_out("multi_b2b2", 1'b1, 3'b111, 8'h00, 1'b0);
        step(); check_out("multi_done", 1'b0, 3'b111, 8'h00, 1'b0);

        // Merge on a held line: counted once
        ready = 1'b0; d = 8'h10; exp_q.push_back(3'b011);
        step(); check_out("merge_cap", 1'b0, 3'b111, 8'h10, 1'b0);
        d = 8'h00;
        step(); check_out("merge_hold", 1'b1, 3'b011, 8'h00, 1'b0);
        d = 8'h10;
        step(); check_out("merge_pulse", 1'b1, 3'b011, 8'h00, 1'b1);
        d = 8'h00;
        step(); check_out("merge_clear", 1'b1, 3'b011, 8'h00, 1'b0);
        // Re-request in the accept cycle: set wins, issued again
        ready = 1'b1; d = 8'h10; exp_q.push_back(3'b011);
        step(); check_out("setwin_cap", 1'b0, 3'b011, 8'h10, 1'b0);
        d = 8'h00;
        step(); check_out("setwin_issue", 1'b1, 3'b011, 8'h00, 1'b0);
        step(); check_out("setwin_done", 1'b0, 3'b011, 8'h00, 1'b0);

        // Enable gating
        enable = 1'b0; d = 8'hFF;
        step(); check_out("gate1", 1'b0, 3'b011, 8'h00, 1'b0);
        step(); check_out("gate2", 1'b0, 3'b011, 8'h00, 1'b0);
        enable = 1'b1; d = 8'h03;
        exp_q.push_back(3'b110); exp_q.push_back(3'b111);
        step(); check_out("drain_cap", 1'b0, 3'b011, 8'h03, 1'b0);
        enable = 1'b0; d = 8'hFF;
        step(); check_out("drain1", 1'b1, 3'b110, 8'h01, 1'b0);
        step(); check_out("drain2", 1'b1, 3'b111, 8'h00, 1'b0);
        step(); check_out("drain_done", 1'b0, 3'b111, 8'h00, 1'b0);

        // Full burst, reset after the third code is accepted
        enable = 1'b1; d = 8'hFF;
        exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
        step(); check_out("burst_cap", 1'b0, 3'b111, 8'hFF, 1'b0);
        d = 8'h00;
        step(); check_out("burst0", 1'b1, 3'd0, 8'h7F, 1'b0);
        step(); check_out("burst1", 1'b1, 3'd1, 8'h3F, 1'b0);
        step(); check_out("burst2", 1'b1, 3'd2, 8'h1F, 1'b0);
        step(); check_out("burst3", 1'b1, 3'd3, 8'h0F, 1'b0);
        reset = 1'b1;
        step(); check_out("midreset", 1'b0, 3'd0, 8'h00, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); check_out("post_reset", 1'b0, 3'd0, 8'h00, 1'b0);
        end

        check("scoreboard_empty", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/line_encoder_sequencer.md
Name: line_encoder_sequencer

Overview:
- Registered priority encoder: the inverse of the team's 3-to-8 line decoder.
- Collects request pulses on 8 input lines into a pending bitmap.
- Issues one binary code per pending line, highest-priority line first, over a Valid/Ready handshake.
- Code mapping is decoder-compatible: feeding Code back into the line decoder (with its Enable high) reproduces the one-hot line, i.e. D[7]->3'b000 ... D[0]->3'b111.

Parameters:
- LINES, 8, number of request lines (power of two, >=2).
- CODE_W, 3, code width; must equal log2(LINES).

Ports:
- Clock  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Enable  input  1  when high, D is captured into Pending this cycle; when low, D is ignored.
- D  input  LINES  request lines; a high bit means request that line, level-sampled per cycle.
- Ready  input  1  consumer accepts Code this cycle when Valid && Ready.
- Valid  output  1  Code holds a pending line's code.
- Code  output  CODE_W  encoded line index; bit order {A,B,C} for LINES=8.
- Pending  output  LINES  registered bitmap of captured, not-yet-issued lines.
- Merge  output  1  one-cycle pulse: a captured request hit a line already pending or held in Code.

Behaviour:
- Reset (Clock edge with Reset=1): Valid=0, Code=0, Pending=0, Merge=0. Reset overrides capture and handshake in the same cycle. Reset mid-handshake discards held and pending requests.
- Priority: line LINES-1 is highest. Issued code for line i = LINES-1-i.
- Output state machine, encoded by the Valid register:
  - EMPTY (Valid=0): if Pending!=0, then next cycle Valid=1, Code=code(highest set bit of Pending), and that bit is cleared from Pending. Otherwise stay EMPTY.
  - HOLD (Valid=1): Code and Valid are stable while Ready=0.
  - HOLD, on Valid && Ready: if Pending (pre-capture value) != 0, load the next code the same cycle and clear its bit; Valid stays 1, giving back-to-back issue with no bubble. Otherwise go to EMPTY.
- Capture: Pending_next = (Pending & ~load_mask) | (Enable ? D : 0).
  - load_mask is the one-hot of the line being loaded this cycle, else 0.
  - Set wins over clear: a line re-asserted in its load cycle remains pending and is issued again later.
- Latency: D[i] high at edge t (with Pending previously empty and output EMPTY) gives Pending[i]=1 after t, then Valid=1 with Code after t+1. The minimum is 2 cycles, and there is no combinational path from D to Code.
- Merge: registered. Set the cycle after any Enable && D[i] where either:
  - Pending[i] is already 1 and not being cleared, or
  - Valid && Code==code(i) && !Ready.
  - Merged requests are not counted; each line is issued at most once per pending episode.
- Enable=0: no capture and Merge=0, but pending lines continue to drain normally.
- All-lines case: D=8'hFF for one cycle issues codes 0..7 in order, one per accepted handshake.
- Ready while Valid=0 has no effect.
- Code width rule: code(i) = CODE_W'(LINES-1-i). Code holds its last value when Valid=0; it is cleared only by Reset.

Decomposition:
- Package line_codec_pkg holds:
  - LINES and CODE_W defaults;
  - the state encoding constants ST_EMPTY and ST_HOLD;
  - function line_to_code(i) returning LINES-1-i.
- One combinational sub-module, line_priority_pick:
  - input: bitmap;
  - outputs: any, code of the highest set bit, one-hot mask of that bit.
- The sequential core instantiates one line_priority_pick on Pending.

Test Plan:
- Reset with D=8'hFF, Enable=1, Reset=1 for 2 cycles -> Valid=0, Code=0, Pending=0, Merge=0 throughout. After release with D=0, the outputs stay at 0.
- Single request: D=8'b00000100 (one cycle, Enable=1), Ready=1 -> Pending=8'h04 after 1 edge, Valid=1 with Code=3'b101 after 2 edges, then Valid=0 the cycle after the accept.
- Multi-request with backpressure: D=8'b10010001 (one cycle), Ready=0 for 4 cycles, then Ready=1 -> Code=000 held stable, then 011, 111 on consecutive cycles, then Valid=0.
- Merge and set-wins: hold Code=3'b011 (line 4) with Ready=0 and pulse D[4] -> Merge=1 for one cycle, and line 4 is issued once. Then pulse D[4] in the exact accept cycle of line 4 -> line 4 is issued again (Code=011 a second time) and Merge=0.
- Enable gating: Enable=0, D=8'hFF -> Pending stays 0 and Valid=0. With Pending=8'h03 and Enable=0, drain with Ready=1 -> Codes 110, 111 issue normally.
- Full burst and mid-operation reset: D=8'hFF, Ready=1 -> Codes 000..111 in order with no bubbles. Assert Reset after the third code -> next cycle Valid=0 and Pending=0, with no further codes issued.
